// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions for the IF, ID and EX stages.
//   - opcode encodings of the supported instruction set
//   - aluOp codes handed from ID to EX
//   - ID/EX control-bundle layout and idExReg field offsets
//   - sign-extension helper for the 16-bit immediate
package instruction_decode_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef struct packed {
    logic       regWrite;
    logic       memToReg;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic       regDst;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam int IDEX_W          = 151;
  localparam int IDEX_CTRL_LSB   = 143;
  localparam int IDEX_PC4_LSB    = 111;
  localparam int IDEX_RSDATA_LSB = 79;
  localparam int IDEX_RTDATA_LSB = 47;
  localparam int IDEX_IMM_LSB    = 15;
  localparam int IDEX_RS_LSB     = 10;
  localparam int IDEX_RT_LSB     = 5;
  localparam int IDEX_RD_LSB     = 0;

  function automatic logic signed [DATA_W-1:0] signExt16(input logic [15:0] imm);
    return $signed({{(DATA_W-16){imm[15]}}, imm});
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Bus between the rest of the pipeline and the ID stage.
//   master: IF/ID register, write-back port, EX/MEM hazard info (driven);
//           branch redirect, stall, ID/EX register, illegalOp (observed)
//   slave : the decode stage itself
interface instruction_decode_if;
  import instruction_decode_pkg::*;

  logic [63:0]        instructionFetchReg;
  logic               wbEnable;
  logic [REG_W-1:0]   wbReg;
  logic [DATA_W-1:0]  wbData;
  logic               exRegWrite;
  logic               exMemRead;
  logic [REG_W-1:0]   exDest;
  logic               memRegWrite;
  logic [REG_W-1:0]   memDest;
  logic               branchResult;
  logic [DATA_W-1:0]  branchAddrs;
  logic               stall;
  logic [IDEX_W-1:0]  idExReg;
  logic               illegalOp;

  modport master (
    output instructionFetchReg, wbEnable, wbReg, wbData,
           exRegWrite, exMemRead, exDest, memRegWrite, memDest,
    input  branchResult, branchAddrs, stall, idExReg, illegalOp
  );

  modport slave (
    input  instructionFetchReg, wbEnable, wbReg, wbData,
           exRegWrite, exMemRead, exDest, memRegWrite, memDest,
    output branchResult, branchAddrs, stall, idExReg, illegalOp
  );
endinterface

// File: rtl/instruction_decode_regfile.sv
// regFile: 32 x 32-bit register file, two read ports, one write port.
//   clk, rst              : clock, async active-high clear of all registers
//   rdAddrA/B, rdDataA/B  : combinational reads; register 0 always reads 0
//   wrEn, wrAddr, wrData  : posedge write, ignored for register 0
// A read of the register being written this cycle returns wrData, so the
// write-back stage and ID can share a cycle without a bypass elsewhere.
module regFile
  import instruction_decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rdAddrA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [REG_W-1:0]  rdAddrB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic              wrEn,
  input  logic [REG_W-1:0]  wrAddr,
  input  logic [DATA_W-1:0] wrData
);
  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wrEn && (wrAddr != '0)) begin
      regs[wrAddr] <= wrData;
    end
  end

  always_comb begin
    rdDataA = regs[rdAddrA];
    rdDataB = regs[rdAddrB];
    if (wrEn && (wrAddr == rdAddrA)) rdDataA = wrData;
    if (wrEn && (wrAddr == rdAddrB)) rdDataB = wrData;
    if (rdAddrA == '0) rdDataA = '0;
    if (rdAddrB == '0) rdDataB = '0;
  end
endmodule

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of the 5-stage pipeline.
//   clk, rst : clock, async active-high reset
//   bus      : IF/ID register, write-back port, EX/MEM destination info in;
//              branch redirect (branchResult/branchAddrs), stall,
//              registered ID/EX register and illegalOp pulse out
// Branches resolve in ID. The cycle after a redirect, the IF/ID contents are
// the wrong-path instruction and are squashed into a bubble.
module instruction_decode
  import instruction_decode_pkg::*;
(
  input  logic clk,
  input  logic rst,
  instruction_decode_if.slave bus
);
  logic [DATA_W-1:0]        instr, pc, pcPlus4, rsData, rtData, target;
  logic signed [DATA_W-1:0] immSext;
  logic [5:0]               opcode;
  logic [REG_W-1:0]         rs, rt, rd;
  ctrl_t                    ctrl;
  logic                     known, usesRt, isBranch, isJump, nopInstr;
  logic                     hazRs, hazRt, stall, taken, branchResult;
  logic [IDEX_W-1:0]        idExNext, idEx_p1;
  logic                     squash_p1, illegal_p1;

  assign instr   = bus.instructionFetchReg[63:32];
  assign pc      = bus.instructionFetchReg[31:0];
  assign pcPlus4 = pc + 32'd4;
  assign opcode  = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign immSext = signExt16(instr[15:0]);

  regFile u_regFile (
    .clk     (clk),
    .rst     (rst),
    .rdAddrA (rs),
    .rdDataA (rsData),
    .rdAddrB (rt),
    .rdDataB (rtData),
    .wrEn    (bus.wbEnable),
    .wrAddr  (bus.wbReg),
    .wrData  (bus.wbData)
  );

  always_comb begin
    ctrl     = '0;
    known    = 1'b1;
    usesRt   = 1'b0;
    isBranch = 1'b0;
    isJump   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl   = '{regWrite: 1'b1, regDst: 1'b1, aluOp: ALU_FUNCT, default: 1'b0};
        usesRt = 1'b1;
      end
      OP_LW:   ctrl = '{regWrite: 1'b1, memToReg: 1'b1, memRead: 1'b1,
                        aluSrc: 1'b1, aluOp: ALU_ADD, default: 1'b0};
      OP_SW: begin
        ctrl   = '{memWrite: 1'b1, aluSrc: 1'b1, aluOp: ALU_ADD, default: 1'b0};
        usesRt = 1'b1;
      end
      OP_ADDI: ctrl = '{regWrite: 1'b1, aluSrc: 1'b1, aluOp: ALU_ADD, default: 1'b0};
      OP_BEQ, OP_BNE: begin
        usesRt   = 1'b1;
        isBranch = 1'b1;
      end
      OP_J:    isJump = 1'b1;
      default: known = 1'b0;
    endcase
    // All-zero word is the canonical NOP even though it parses as R-type.
    if (instr == '0) ctrl = '0;
  end

  // A squashed slot behaves as a NOP regardless of what IF delivered.
  assign nopInstr = squash_p1 || (instr == '0);

  assign hazRs = (rs != '0) &&
                 ((bus.exMemRead && (bus.exDest == rs)) ||
                  (isBranch && ((bus.exRegWrite && (bus.exDest == rs)) ||
                                (bus.memRegWrite && (bus.memDest == rs)))));
  assign hazRt = (rt != '0) &&
                 ((bus.exMemRead && (bus.exDest == rt)) ||
                  (isBranch && ((bus.exRegWrite && (bus.exDest == rt)) ||
                                (bus.memRegWrite && (bus.memDest == rt)))));

  assign stall = !rst && !nopInstr && (hazRs || (usesRt && hazRt));

  assign taken  = isJump ||
                  (isBranch && ((opcode == OP_BEQ) == (rsData == rtData)));
  assign target = isJump ? {pcPlus4[31:28], instr[25:0], 2'b00}
                         : pcPlus4 + $unsigned(immSext <<< 2);

  assign branchResult = !rst && !nopInstr && !stall && taken;

  assign idExNext = (stall || squash_p1) ? '0
                  : {ctrl, pcPlus4, rsData, rtData, immSext, rs, rt, rd};

  // ---- ID -> EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idEx_p1    <= '0;
      squash_p1  <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      idEx_p1    <= idExNext;
      squash_p1  <= branchResult;
      illegal_p1 <= !squash_p1 && !stall && !known;
    end
  end

  assign bus.branchResult = branchResult;
  assign bus.branchAddrs  = branchResult ? target : '0;
  assign bus.stall        = stall;
  assign bus.idExReg      = idEx_p1;
  assign bus.illegalOp    = illegal_p1;
endmodule

// File: tb/tb_instruction_decode.sv
module tb_instruction_decode;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instruction_decode_if bus ();
  instruction_decode dut (.clk(clk), .rst(rst), .bus(bus));

  // reference state
  logic [31:0] refRegs [32];
  logic        mSquash;
  logic        obsStall, obsBr;
  logic [31:0] obsAddr;

  task automatic check(input string tag, input logic [150:0] got, input logic [150:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] readReg(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (bus.wbEnable && bus.wbReg == r) return bus.wbData;
    return refRegs[r];
  endfunction

  function automatic logic haz(input logic [4:0] s, input logic br);
    if (s == 0) return 1'b0;
    if (bus.exMemRead && bus.exDest == s) return 1'b1;
    if (br && bus.exRegWrite && bus.exDest == s) return 1'b1;
    if (br && bus.memRegWrite && bus.memDest == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    mSquash = 1'b0;
  endtask

  task automatic setIn(input logic [31:0] instr, input logic [31:0] pc);
    bus.instructionFetchReg = {instr, pc};
  endtask

  task automatic quiet();
    bus.wbEnable = 0; bus.wbReg = 0; bus.wbData = 0;
    bus.exRegWrite = 0; bus.exMemRead = 0; bus.exDest = 0;
    bus.memRegWrite = 0; bus.memDest = 0;
  endtask

  // One clock: check combinational outputs mid-cycle, then the registered
  // outputs just after the edge, against the instruction-level model.
  task automatic cycle();
    logic [31:0]  instr, pc, pc4, a, b, sx, tgt;
    logic [5:0]   op;
    logic [4:0]   rs, rt, rd;
    logic         nopI, known, usesRt, isBr, taken, eStall, eBr, eIll, doWr;
    logic [7:0]   ctrl;
    logic [150:0] eIdEx;
    logic [4:0]   wrR;
    logic [31:0]  wrD;
    #2;
    instr = bus.instructionFetchReg[63:32];
    pc    = bus.instructionFetchReg[31:0];
    pc4   = pc + 32'd4;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    a  = readReg(rs);
    b  = readReg(rt);
    sx = {{16{instr[15]}}, instr[15:0]};
    nopI = mSquash || (instr == 0);
    known = 1; usesRt = 0; ctrl = 8'h00;
    case (op)
      6'h00: begin ctrl = 8'b10000110; usesRt = 1; end
      6'h23: ctrl = 8'b11101000;
      6'h2B: begin ctrl = 8'b00011000; usesRt = 1; end
      6'h08: ctrl = 8'b10001000;
      6'h04, 6'h05: usesRt = 1;
      6'h02: ;
      default: known = 0;
    endcase
    if (instr == 0) ctrl = 8'h00;
    isBr   = (op == 6'h04) || (op == 6'h05);
    eStall = !nopI && (haz(rs, isBr) || (usesRt && haz(rt, isBr)));
    taken  = (op == 6'h04 && a == b) || (op == 6'h05 && a != b) || (op == 6'h02);
    eBr    = !nopI && !eStall && taken;
    tgt    = (op == 6'h02) ? {pc4[31:28], instr[25:0], 2'b00} : pc4 + (sx << 2);
    obsStall = bus.stall; obsBr = bus.branchResult; obsAddr = bus.branchAddrs;
    check("stall", {150'd0, bus.stall}, {150'd0, eStall});
    check("branchResult", {150'd0, bus.branchResult}, {150'd0, eBr});
    check("branchAddrs", {119'd0, bus.branchAddrs}, {119'd0, eBr ? tgt : 32'd0});
    eIdEx = (eStall || mSquash) ? 151'd0 : {ctrl, pc4, a, b, sx, rs, rt, rd};
    eIll  = !mSquash && !eStall && !known;
    doWr = bus.wbEnable && bus.wbReg != 0; wrR = bus.wbReg; wrD = bus.wbData;
    @(posedge clk); #1;
    if (doWr) refRegs[wrR] = wrD;
    mSquash = eBr;
    check("idExReg", bus.idExReg, eIdEx);
    check("illegalOp", {150'd0, bus.illegalOp}, {150'd0, eIll});
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [5:0] opTab [8];
    logic [5:0] op;
    logic [31:0] instr;
    int sel;
    opTab = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3F};
    quiet();
    setIn(32'h0, 32'h0);
    rst = 1'b1;
    modelReset();
    @(posedge clk); #1;
    setIn(32'h8C220004, 32'h10);
    #2;
    check("rst_idExReg", bus.idExReg, 151'd0);
    check("rst_illegalOp", {150'd0, bus.illegalOp}, 151'd0);
    check("rst_stall", {150'd0, bus.stall}, 151'd0);
    check("rst_branch", {150'd0, bus.branchResult}, 151'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // lw $2,4($1) at PC 0x10
    cycle();
    check("lw_ctrl", {143'd0, bus.idExReg[150:143]}, {143'd0, 8'b11101000});
    check("lw_pc4", {119'd0, bus.idExReg[142:111]}, {119'd0, 32'h14});
    check("lw_imm", {119'd0, bus.idExReg[46:15]}, {119'd0, 32'd4});

    // load-use hazard on add $3,$2,$4
    setIn(32'h00441820, 32'h14);
    bus.exMemRead = 1; bus.exDest = 2;
    cycle();
    check("lu_stall", {150'd0, obsStall}, {150'd0, 1'b1});
    check("lu_bubble", bus.idExReg, 151'd0);
    bus.exMemRead = 0;
    cycle();
    check("add_ctrl", {143'd0, bus.idExReg[150:143]}, {143'd0, 8'b10000110});

    // $1 = $2 = 5, then beq $1,$2,+3 at 0x20
    setIn(32'h0, 32'h18);
    bus.wbEnable = 1; bus.wbReg = 1; bus.wbData = 5;
    cycle();
    bus.wbReg = 2;
    cycle();
    bus.wbEnable = 0;
    setIn(32'h10220003, 32'h20);
    cycle();
    check("beq_taken", {150'd0, obsBr}, {150'd0, 1'b1});
    check("beq_target", {119'd0, obsAddr}, {119'd0, 32'h30});
    setIn(32'h8C220004, 32'h24);
    cycle();
    check("squash_bubble", bus.idExReg, 151'd0);
    check("squash_nobranch", {150'd0, obsBr}, 151'd0);

    // j 0x40 at 0xF0000000
    setIn(32'h08000040, 32'hF0000000);
    cycle();
    check("j_target", {119'd0, obsAddr}, {119'd0, 32'hF0000100});
    setIn(32'h0, 32'hF0000004);
    cycle();

    // write-through: or $6,$5,$0 while writing $5
    setIn(32'h00A03025, 32'h40);
    bus.wbEnable = 1; bus.wbReg = 5; bus.wbData = 32'hDEAD;
    cycle();
    check("wt_rsData", {119'd0, bus.idExReg[110:79]}, {119'd0, 32'hDEAD});
    setIn(32'h00003025, 32'h44);
    bus.wbReg = 0; bus.wbData = 32'hBEEF;
    cycle();
    check("r0_same", {119'd0, bus.idExReg[110:79]}, 151'd0);
    bus.wbEnable = 0;
    cycle();
    check("r0_after", {119'd0, bus.idExReg[110:79]}, 151'd0);

    // illegal opcode
    setIn(32'hFC000000, 32'h48);
    cycle();
    check("ill_ctrl", {143'd0, bus.idExReg[150:143]}, 151'd0);
    check("ill_pulse", {150'd0, bus.illegalOp}, {150'd0, 1'b1});
    setIn(32'h0, 32'h4C);
    cycle();
    check("ill_oneshot", {150'd0, bus.illegalOp}, 151'd0);

    // reset in the middle of a stall
    setIn(32'h00441820, 32'h50);
    bus.exMemRead = 1; bus.exDest = 2;
    #2;
    check("pre_rst_stall", {150'd0, bus.stall}, {150'd0, 1'b1});
    rst = 1'b1;
    #1;
    check("rst_drops_stall", {150'd0, bus.stall}, 151'd0);
    check("rst_clr_idex", bus.idExReg, 151'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    quiet();

    // reset in the middle of a squash
    bus.wbEnable = 1; bus.wbReg = 7; bus.wbData = 9;
    setIn(32'h0, 32'h60);
    cycle();
    bus.wbEnable = 0;
    setIn(32'h10E70002, 32'h64);
    cycle();
    doReset();
    setIn(32'h8C220004, 32'h68);
    cycle();
    check("rst_abandons_squash", {143'd0, bus.idExReg[150:143]}, {143'd0, 8'b11101000});

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 8);
      if (sel == 8) instr = 32'h0;
      else begin
        op = (sel == 7) ? 6'($urandom) : opTab[sel];
        instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 8))};
      end
      setIn(instr, $urandom_range(0, 1) != 0 ? $urandom : {$urandom_range(0, 255), 2'b00});
      bus.wbEnable    = 1'($urandom_range(0, 1));
      bus.wbReg       = 5'($urandom_range(0, 7));
      bus.wbData      = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.exRegWrite  = ($urandom_range(0, 3) == 0);
      bus.exMemRead   = ($urandom_range(0, 3) == 0);
      bus.exDest      = 5'($urandom_range(0, 7));
      bus.memRegWrite = ($urandom_range(0, 3) == 0);
      bus.memDest     = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
